// File: rtl/header_lsu_if.sv
// ----------------------------------------------------------------------------
// header_lsu_if
// Purpose : bundles the core request/response handshake and the memory
//           request/response bus of header_lsu into one interface.
// Modports:
//   slave  - the LSU side (receives core requests, issues memory requests)
//   master - the environment side (core + memory)
// Signals : req_*       core request {op, addr, size, next_addr} + valid
//           lsu_ready_o request accept
//           rsp_*       one-cycle response pulse and payload
//           mem_*       word-wide memory request/response channel
// ----------------------------------------------------------------------------
interface header_lsu_if #(
    parameter int unsigned DATA_W = 64
);
    logic              req_val_i;
    logic [1:0]        req_op_i;
    logic [DATA_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_size_i;
    logic [DATA_W-1:0] req_next_addr_i;
    logic              lsu_ready_o;

    logic              rsp_val_o;
    logic [DATA_W-1:0] rsp_size_o;
    logic [DATA_W-1:0] rsp_addr_o;
    logic [DATA_W-1:0] rsp_next_addr_o;
    logic              rsp_err_o;

    logic              mem_req_val_o;
    logic              mem_req_ready_i;
    logic              mem_we_o;
    logic [DATA_W-1:0] mem_addr_o;
    logic [DATA_W-1:0] mem_wdata_o;
    logic              mem_rsp_val_i;
    logic [DATA_W-1:0] mem_rdata_i;

    modport slave (
        input  req_val_i, req_op_i, req_addr_i, req_size_i, req_next_addr_i,
        output lsu_ready_o,
        output rsp_val_o, rsp_size_o, rsp_addr_o, rsp_next_addr_o, rsp_err_o,
        output mem_req_val_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_req_ready_i, mem_rsp_val_i, mem_rdata_i
    );

    modport master (
        output req_val_i, req_op_i, req_addr_i, req_size_i, req_next_addr_i,
        input  lsu_ready_o,
        input  rsp_val_o, rsp_size_o, rsp_addr_o, rsp_next_addr_o, rsp_err_o,
        input  mem_req_val_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_req_ready_i, mem_rsp_val_i, mem_rdata_i
    );
endinterface

// File: rtl/header_lsu.sv
// ----------------------------------------------------------------------------
// header_lsu
// Purpose : executes allocator header requests {op, addr, size, next_addr}
//           as word-wide memory transactions and returns one response per
//           request. Header layout: word0 @addr = size,
//           word1 @addr+WORD_BYTES = next_addr.
// Ports   : clk_i  - clock
//           rst_ni - synchronous active-low reset
//           bus    - header_lsu_if.slave (core request/response, memory bus)
// Ops     : 0 LOAD_HDR   read word0 and word1
//           1 STORE_HDR  write word0 then word1
//           2 STORE_SIZE write word0 only
//           3 STORE_NEXT write word1 only
// Config  : LSU_ALIGN_CHECK_EN - when defined, a request whose address is not
//           word aligned produces no memory traffic and an error response.
//           Undefined: rsp_err_o is 0 and addresses pass through unchanged.
// All outputs come straight from flops.
// ----------------------------------------------------------------------------
module header_lsu #(
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned WORD_BYTES = DATA_W / 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    header_lsu_if.slave bus
);

    typedef enum logic [1:0] {
        OP_LOAD_HDR   = 2'd0,
        OP_STORE_HDR  = 2'd1,
        OP_STORE_SIZE = 2'd2,
        OP_STORE_NEXT = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE0,
        S_WAIT0,
        S_ISSUE1,
        S_WAIT1,
        S_RESP,
        S_ALIGN_ERR
    } state_e;

    localparam logic [DATA_W-1:0] WORD_STRIDE = DATA_W'(WORD_BYTES);

    state_e            state_q, state_d;
    logic              init_q, init_d;
    logic              ready_q, ready_d;
    op_e               op_q, op_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] size_q, size_d;
    logic [DATA_W-1:0] next_q, next_d;
    logic [DATA_W-1:0] rdata0_q, rdata0_d;

    logic              mem_val_q, mem_val_d;
    logic              mem_we_q, mem_we_d;
    logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic              rsp_val_q, rsp_val_d;
    logic [DATA_W-1:0] rsp_size_q, rsp_size_d;
    logic [DATA_W-1:0] rsp_addr_q, rsp_addr_d;
    logic [DATA_W-1:0] rsp_next_q, rsp_next_d;
`ifdef LSU_ALIGN_CHECK_EN
    logic              rsp_err_q, rsp_err_d;
`endif

    // First memory beat derived from the incoming request
    op_e               req_op;
    logic              first_we;
    logic [DATA_W-1:0] first_addr;
    logic [DATA_W-1:0] first_wdata;

    always_comb begin
        req_op      = op_e'(bus.req_op_i);
        first_we    = (req_op != OP_LOAD_HDR);
        // STORE_NEXT touches only word1; address wraps modulo 2^DATA_W
        first_addr  = (req_op == OP_STORE_NEXT) ? bus.req_addr_i + WORD_STRIDE
                                                : bus.req_addr_i;
        first_wdata = (req_op == OP_STORE_NEXT) ? bus.req_next_addr_i :
                      (req_op == OP_LOAD_HDR)   ? mem_wdata_q
                                                : bus.req_size_i;
    end

    always_comb begin
        state_d     = state_q;
        init_d      = 1'b1;
        ready_d     = 1'b0;
        op_d        = op_q;
        addr_d      = addr_q;
        size_d      = size_q;
        next_d      = next_q;
        rdata0_d    = rdata0_q;
        mem_val_d   = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_val_d   = 1'b0;
        rsp_size_d  = rsp_size_q;
        rsp_addr_d  = rsp_addr_q;
        rsp_next_d  = rsp_next_q;
`ifdef LSU_ALIGN_CHECK_EN
        rsp_err_d   = rsp_err_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                // init_q keeps ready low for the first cycle after reset
                ready_d = init_q;
                if (ready_q && bus.req_val_i) begin
                    ready_d     = 1'b0;
                    op_d        = req_op;
                    addr_d      = bus.req_addr_i;
                    size_d      = bus.req_size_i;
                    next_d      = bus.req_next_addr_i;
                    state_d     = S_ISSUE0;
                    mem_val_d   = 1'b1;
                    mem_we_d    = first_we;
                    mem_addr_d  = first_addr;
                    mem_wdata_d = first_wdata;
`ifdef LSU_ALIGN_CHECK_EN
                    if ((bus.req_addr_i % WORD_STRIDE) != '0) begin
                        state_d     = S_ALIGN_ERR;
                        mem_val_d   = 1'b0;
                        mem_we_d    = mem_we_q;
                        mem_addr_d  = mem_addr_q;
                        mem_wdata_d = mem_wdata_q;
                    end
`endif
                end
            end

            S_ISSUE0, S_ISSUE1: begin
                mem_val_d = 1'b1;
                if (bus.mem_req_ready_i) begin
                    mem_val_d = 1'b0;
                    state_d   = (state_q == S_ISSUE0) ? S_WAIT0 : S_WAIT1;
                end
            end

            S_WAIT0: begin
                if (bus.mem_rsp_val_i) begin
                    if (op_q == OP_LOAD_HDR) begin
                        rdata0_d = bus.mem_rdata_i;
                    end
                    if (op_q == OP_LOAD_HDR || op_q == OP_STORE_HDR) begin
                        state_d     = S_ISSUE1;
                        mem_val_d   = 1'b1;
                        mem_we_d    = (op_q != OP_LOAD_HDR);
                        mem_addr_d  = addr_q + WORD_STRIDE;
                        mem_wdata_d = next_q;
                    end else begin
                        state_d    = S_RESP;
                        rsp_val_d  = 1'b1;
                        rsp_size_d = size_q;
                        rsp_addr_d = addr_q;
                        rsp_next_d = next_q;
`ifdef LSU_ALIGN_CHECK_EN
                        rsp_err_d  = 1'b0;
`endif
                    end
                end
            end

            S_WAIT1: begin
                if (bus.mem_rsp_val_i) begin
                    state_d    = S_RESP;
                    rsp_val_d  = 1'b1;
                    rsp_addr_d = addr_q;
                    rsp_size_d = (op_q == OP_LOAD_HDR) ? rdata0_q : size_q;
                    rsp_next_d = (op_q == OP_LOAD_HDR) ? bus.mem_rdata_i : next_q;
`ifdef LSU_ALIGN_CHECK_EN
                    rsp_err_d  = 1'b0;
`endif
                end
            end

            S_RESP: begin
                state_d = S_IDLE;
                ready_d = 1'b1;
            end

            S_ALIGN_ERR: begin
                state_d    = S_RESP;
                rsp_val_d  = 1'b1;
                rsp_size_d = '0;
                rsp_addr_d = addr_q;
                rsp_next_d = '0;
`ifdef LSU_ALIGN_CHECK_EN
                rsp_err_d  = 1'b1;
`endif
            end

            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            init_q      <= 1'b0;
            ready_q     <= 1'b0;
            op_q        <= OP_LOAD_HDR;
            addr_q      <= '0;
            size_q      <= '0;
            next_q      <= '0;
            rdata0_q    <= '0;
            mem_val_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_val_q   <= 1'b0;
            rsp_size_q  <= '0;
            rsp_addr_q  <= '0;
            rsp_next_q  <= '0;
`ifdef LSU_ALIGN_CHECK_EN
            rsp_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            init_q      <= init_d;
            ready_q     <= ready_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            size_q      <= size_d;
            next_q      <= next_d;
            rdata0_q    <= rdata0_d;
            mem_val_q   <= mem_val_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            rsp_val_q   <= rsp_val_d;
            rsp_size_q  <= rsp_size_d;
            rsp_addr_q  <= rsp_addr_d;
            rsp_next_q  <= rsp_next_d;
`ifdef LSU_ALIGN_CHECK_EN
            rsp_err_q   <= rsp_err_d;
`endif
        end
    end

    assign bus.lsu_ready_o     = ready_q;
    assign bus.mem_req_val_o   = mem_val_q;
    assign bus.mem_we_o        = mem_we_q;
    assign bus.mem_addr_o      = mem_addr_q;
    assign bus.mem_wdata_o     = mem_wdata_q;
    assign bus.rsp_val_o       = rsp_val_q;
    assign bus.rsp_size_o      = rsp_size_q;
    assign bus.rsp_addr_o      = rsp_addr_q;
    assign bus.rsp_next_addr_o = rsp_next_q;
`ifdef LSU_ALIGN_CHECK_EN
    assign bus.rsp_err_o       = rsp_err_q;
`else
    assign bus.rsp_err_o       = 1'b0;
`endif

endmodule
